dmac_main_ctrl: RTL and testbench

//  Control FSM driving Dmac_Main_Datapath. Arbitrates peripheral DMA requests and fetches the
//  4-word config block (SAddr, DAddr, Size, Ctrl) over the AHB master port. It then enables

---
 rtl/dmac_main_ctrl.sv | 157 +++++++++++++++
 tb/tb_dmac_main_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_main_ctrl.sv
// rtl/dmac_main_ctrl.sv - DMA main control FSM: request arbitration, config fetch, channel run
// One peripheral request at a time: fetch 4 config words, run a channel until irq, ack, drop.
module dmac_main_ctrl #(
  parameter int unsigned     TO_W   = 16,
  parameter logic [TO_W-1:0] TO_CYC = '1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] DmacReq,
  input  logic       HReady,
  input  logic [1:0] M_HResp,
  input  logic       irq,
  input  logic       C_config,
  output logic [1:0] con_sel,
  output logic       con_en,
  output logic [1:0] config_HTrans,
  output logic       config_write,
  output logic [1:0] addr_inc_sel,
  output logic       DmacReq_Reg_en,
  output logic       PeriAddr_reg_en,
  output logic       SAddr_Reg_en,
  output logic       DAddr_Reg_en,
  output logic       Trans_sz_Reg_en,
  output logic       Ctrl_Reg_en,
  output logic       channel_en_1,
  output logic       channel_en_2,
  output logic [1:0] dmac_ack,
  output logic       busy,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_CFG_A, S_CFG_D, S_SEL, S_RUN, S_DONE, S_ERR, S_DROP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_CYC - TO_W'(1);

  state_t          state, state_nx;
  logic [1:0]      k;
  logic [1:0]      gnt;
  logic [1:0]      sel_q;
  logic            err_q;
  logic [TO_W-1:0] wdog;
  logic            bus_err;
  logic            wd_hit;

  assign bus_err = HReady && (M_HResp == 2'b01);
  assign wd_hit  = (TO_CYC != '0) && (wdog == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= 2'b00;
      gnt   <= 2'b00;
      sel_q <= 2'b10;
      err_q <= 1'b0;
      wdog  <= '0;
    end else begin
      // Grant is frozen when leaving IDLE; later request changes are ignored until DROP.
      if (state == S_IDLE && DmacReq != 2'b00)
        gnt <= DmacReq[1] ? 2'b10 : 2'b01;
      case (state)
        S_LATCH: begin
          k     <= 2'b00;
          err_q <= 1'b0;
        end
        S_CFG_D: if (HReady && !bus_err && k != 2'b11) k <= k + 2'b01;
        S_SEL: begin
          sel_q <= {1'b0, C_config};
          wdog  <= '0;
        end
        S_RUN:  if (wdog != '1) wdog <= wdog + TO_W'(1);
        S_DONE: sel_q <= 2'b10;
        S_ERR: begin
          sel_q <= 2'b10;
          err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (DmacReq != 2'b00) state_nx = S_LATCH;
      S_LATCH: state_nx = S_CFG_A;
      S_CFG_A: if (HReady) state_nx = S_CFG_D;
      S_CFG_D: if (HReady) state_nx = bus_err ? S_ERR : (k == 2'b11 ? S_SEL : S_CFG_A);
      S_SEL:   state_nx = S_RUN;
      S_RUN: begin
        if (irq)                   state_nx = S_DONE;
        else if (bus_err || wd_hit) state_nx = S_ERR;
      end
      S_DONE:  state_nx = S_DROP;
      S_ERR:   state_nx = S_DROP;
      S_DROP:  if ((DmacReq & gnt) == 2'b00) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    con_en          = 1'b0;
    config_HTrans   = 2'b00;
    addr_inc_sel    = 2'b00;
    DmacReq_Reg_en  = 1'b0;
    PeriAddr_reg_en = 1'b0;
    SAddr_Reg_en    = 1'b0;
    DAddr_Reg_en    = 1'b0;
    Trans_sz_Reg_en = 1'b0;
    Ctrl_Reg_en     = 1'b0;
    channel_en_1    = 1'b0;
    channel_en_2    = 1'b0;
    dmac_ack        = 2'b00;
    case (state)
      S_LATCH: begin
        con_en          = 1'b1;
        DmacReq_Reg_en  = 1'b1;
        PeriAddr_reg_en = 1'b1;
      end
      S_CFG_A: begin
        config_HTrans = 2'b10;
        addr_inc_sel  = k;
      end
      S_CFG_D: begin
        addr_inc_sel = k;
        if (HReady && !bus_err) begin
          SAddr_Reg_en    = (k == 2'b00);
          DAddr_Reg_en    = (k == 2'b01);
          Trans_sz_Reg_en = (k == 2'b10);
          Ctrl_Reg_en     = (k == 2'b11);
        end
      end
      S_SEL: con_en = 1'b1;
      S_RUN: begin
        channel_en_1 = (sel_q == 2'b00);
        channel_en_2 = (sel_q == 2'b01);
      end
      S_DONE: begin
        con_en   = 1'b1;
        dmac_ack = gnt;
      end
      S_ERR:   con_en = 1'b1;
      default: ;
    endcase
  end

  assign con_sel      = sel_q;
  assign config_write = 1'b0;
  assign busy         = (state != S_IDLE);
  assign err          = err_q || (state == S_ERR);

endmodule

// File: tb/tb_dmac_main_ctrl.sv
// tb/tb_dmac_main_ctrl.sv - self-checking bench for dmac_main_ctrl
// A transaction generator lays out the expected per-cycle output timeline from the protocol rules.
module tb_dmac_main_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] DmacReq = 2'b00;
  logic       HReady = 1'b1;
  logic [1:0] M_HResp = 2'b00;
  logic       irq = 1'b0;
  logic       C_config = 1'b0;
  logic [1:0] con_sel, config_HTrans, addr_inc_sel, dmac_ack;
  logic       con_en, config_write, DmacReq_Reg_en, PeriAddr_reg_en;
  logic       SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en;
  logic       channel_en_1, channel_en_2, busy, err;

  dmac_main_ctrl #(.TO_W(16), .TO_CYC(16'd16)) dut (
    .clk(clk), .rst(rst), .DmacReq(DmacReq), .HReady(HReady), .M_HResp(M_HResp),
    .irq(irq), .C_config(C_config), .con_sel(con_sel), .con_en(con_en),
    .config_HTrans(config_HTrans), .config_write(config_write), .addr_inc_sel(addr_inc_sel),
    .DmacReq_Reg_en(DmacReq_Reg_en), .PeriAddr_reg_en(PeriAddr_reg_en),
    .SAddr_Reg_en(SAddr_Reg_en), .DAddr_Reg_en(DAddr_Reg_en),
    .Trans_sz_Reg_en(Trans_sz_Reg_en), .Ctrl_Reg_en(Ctrl_Reg_en),
    .channel_en_1(channel_en_1), .channel_en_2(channel_en_2), .dmac_ack(dmac_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] con_sel;
    logic       con_en;
    logic [1:0] htrans;
    logic       wr;
    logic [1:0] addr;
    logic       dreq_en;
    logic       peri_en;
    logic [3:0] wen;
    logic       ch1;
    logic       ch2;
    logic [1:0] ack;
    logic       busy;
    logic       err;
  } out_t;

  typedef struct {
    logic       hready;
    logic [1:0] hresp;
    logic       irq;
    logic [1:0] req;
    logic       cfg;
    out_t       e;
  } step_t;

  out_t  obs;
  out_t  rv;
  step_t sched[$];
  int    checks = 0;
  int    failures = 0;
  logic  model_err = 1'b0;
  int    run_idx = 0;

  assign obs = {con_sel, con_en, config_HTrans, config_write, addr_inc_sel, DmacReq_Reg_en,
                PeriAddr_reg_en, Ctrl_Reg_en, Trans_sz_Reg_en, DAddr_Reg_en, SAddr_Reg_en,
                channel_en_1, channel_en_2, dmac_ack, busy, err};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rr();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [1:0] rresp();
    return 2'($urandom_range(0, 1));
  endfunction

  function automatic out_t base(input logic b);
    out_t o;
    o = '0;
    o.con_sel = 2'b10;
    o.busy = b;
    o.err = model_err;
    return o;
  endfunction

  task automatic push(input logic hr, input logic [1:0] hp, input logic iq,
                      input logic [1:0] rq, input logic cf, input out_t e);
    step_t s;
    s.hready = hr; s.hresp = hp; s.irq = iq; s.req = rq; s.cfg = cf; s.e = e;
    sched.push_back(s);
  endtask

  // mode 0: irq after `quiet` RUN cycles; 1: watchdog expiry; 2: bus error after `quiet` cycles
  task automatic gen_txn(input logic [1:0] req_in, input logic ctrl, input int mode,
                         input int quiet, input int err_word, input int sa[4], input int sd[4],
                         input logic [1:0] drop_req);
    out_t       e;
    logic [1:0] g, sel, cs;
    logic       hr;
    bit         failed;
    int         n;
    failed = 0;
    g = req_in[1] ? 2'b10 : 2'b01;
    sel = {1'b0, ctrl};
    cs = 2'b10;
    e = base(1'b0);
    push(rb(), rresp(), rb(), req_in, rb(), e);
    e = base(1'b1); e.con_en = 1; e.dreq_en = 1; e.peri_en = 1;
    push(rb(), rresp(), rb(), rr(), rb(), e);
    model_err = 1'b0;
    for (int k = 0; k < 4 && !failed; k++) begin
      for (int i = 0; i < sa[k]; i++) begin
        e = base(1'b1); e.htrans = 2'b10; e.addr = 2'(k);
        push(1'b0, rresp(), rb(), rr(), rb(), e);
      end
      e = base(1'b1); e.htrans = 2'b10; e.addr = 2'(k);
      push(1'b1, rresp(), rb(), rr(), rb(), e);
      for (int i = 0; i < sd[k]; i++) begin
        e = base(1'b1); e.addr = 2'(k);
        push(1'b0, rresp(), rb(), rr(), rb(), e);
      end
      e = base(1'b1); e.addr = 2'(k);
      if (k == err_word) begin
        push(1'b1, 2'b01, rb(), rr(), rb(), e);
        failed = 1;
      end else begin
        e.wen[k] = 1'b1;
        push(1'b1, 2'b00, rb(), rr(), rb(), e);
      end
    end
    if (!failed) begin
      e = base(1'b1); e.con_en = 1;
      push(rb(), rresp(), rb(), rr(), ctrl, e);
      run_idx = sched.size();
      e = base(1'b1); e.con_sel = sel; e.ch1 = ~ctrl; e.ch2 = ctrl;
      n = (mode == 1) ? 16 : quiet;
      for (int i = 0; i < n; i++) begin
        hr = rb();
        push(hr, hr ? 2'b00 : rresp(), 1'b0, rr(), rb(), e);
      end
      cs = sel;
      if (mode == 0) begin
        push(rb(), 2'b00, 1'b1, rr(), rb(), e);
        e = base(1'b1); e.con_sel = sel; e.con_en = 1; e.ack = g;
        push(rb(), rresp(), rb(), rr(), rb(), e);
      end else if (mode == 2) begin
        push(1'b1, 2'b01, 1'b0, rr(), rb(), e);
      end
    end
    if (failed || mode != 0) begin
      e = base(1'b1); e.con_sel = cs; e.con_en = 1; e.err = 1;
      push(rb(), rresp(), rb(), rr(), rb(), e);
      model_err = 1'b1;
    end
    e = base(1'b1);
    push(rb(), rresp(), rb(), req_in, rb(), e);
    push(rb(), rresp(), rb(), drop_req, rb(), e);
  endtask

  task automatic test_reset();
    rv = '0;
    rv.con_sel = 2'b10;
    #1 rst = 1'b1;
    DmacReq = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (obs !== rv) begin
        failures++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, obs, rv);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    DmacReq = 2'b00;
    #1;
    checks++;
    if (obs !== rv) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", obs, rv);
    end
  endtask

  task automatic test_basic();
    int z[4] = '{0, 0, 0, 0};
    sched.delete();
    gen_txn(2'b01, 1'b0, 0, 3, 4, z, z, 2'b00);
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      HReady = sched[i].hready; M_HResp = sched[i].hresp; irq = sched[i].irq;
      DmacReq = sched[i].req; C_config = sched[i].cfg;
      #1;
      checks++;
      if (obs !== sched[i].e) begin
        failures++;
        $display("FAIL basic step %0d: got %h expected %h", i, obs, sched[i].e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int z[4] = '{0, 0, 0, 0};
    sched.delete();
    gen_txn(2'b11, 1'b1, 0, 2, 4, z, z, 2'b01);
    gen_txn(2'b01, 1'b0, 0, 0, 4, z, z, 2'b00);
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      HReady = sched[i].hready; M_HResp = sched[i].hresp; irq = sched[i].irq;
      DmacReq = sched[i].req; C_config = sched[i].cfg;
      #1;
      checks++;
      if (obs !== sched[i].e) begin
        failures++;
        $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, sched[i].e);
      end
    end
  endtask

  task automatic test_stall();
    int z[4] = '{0, 0, 0, 0};
    int d[4] = '{0, 0, 3, 0};
    int a[4] = '{1, 0, 2, 0};
    sched.delete();
    gen_txn(2'b10, 1'b0, 0, 1, 4, z, d, 2'b00);
    gen_txn(2'b01, 1'b1, 0, 4, 4, a, d, 2'b00);
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      HReady = sched[i].hready; M_HResp = sched[i].hresp; irq = sched[i].irq;
      DmacReq = sched[i].req; C_config = sched[i].cfg;
      #1;
      checks++;
      if (obs !== sched[i].e) begin
        failures++;
        $display("FAIL stall step %0d: got %h expected %h", i, obs, sched[i].e);
      end
    end
  endtask

  task automatic test_bus_err();
    int z[4] = '{0, 0, 0, 0};
    sched.delete();
    gen_txn(2'b01, 1'b0, 0, 0, 1, z, z, 2'b00);
    gen_txn(2'b10, 1'b1, 0, 5, 4, z, z, 2'b00);
    gen_txn(2'b01, 1'b1, 2, 6, 4, z, z, 2'b00);
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      HReady = sched[i].hready; M_HResp = sched[i].hresp; irq = sched[i].irq;
      DmacReq = sched[i].req; C_config = sched[i].cfg;
      #1;
      checks++;
      if (obs !== sched[i].e) begin
        failures++;
        $display("FAIL bus_err step %0d: got %h expected %h", i, obs, sched[i].e);
      end
    end
  endtask

  task automatic test_timeout();
    int z[4] = '{0, 0, 0, 0};
    sched.delete();
    gen_txn(2'b01, 1'b1, 1, 0, 4, z, z, 2'b00);
    gen_txn(2'b10, 1'b0, 0, 15, 4, z, z, 2'b00);
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      HReady = sched[i].hready; M_HResp = sched[i].hresp; irq = sched[i].irq;
      DmacReq = sched[i].req; C_config = sched[i].cfg;
      #1;
      checks++;
      if (obs !== sched[i].e) begin
        failures++;
        $display("FAIL timeout step %0d: got %h expected %h", i, obs, sched[i].e);
      end
    end
    sched.delete();
    gen_txn(2'b10, 1'b1, 0, 10, 4, z, z, 2'b00);
    for (int i = 0; i < run_idx + 3; i++) begin
      @(negedge clk);
      HReady = sched[i].hready; M_HResp = sched[i].hresp; irq = sched[i].irq;
      DmacReq = sched[i].req; C_config = sched[i].cfg;
      #1;
      checks++;
      if (obs !== sched[i].e) begin
        failures++;
        $display("FAIL pre_reset step %0d: got %h expected %h", i, obs, sched[i].e);
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== rv) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h", obs, rv);
    end
    @(negedge clk);
    rst = 1'b0;
    DmacReq = 2'b00;
    model_err = 1'b0;
    sched.delete();
  endtask

  task automatic test_random();
    int         a[4], d[4];
    logic [1:0] rq, g;
    int         mode, ew;
    sched.delete();
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < 4; k++) begin
        a[k] = $urandom_range(0, 2);
        d[k] = $urandom_range(0, 2);
      end
      rq = 2'($urandom_range(1, 3));
      g = rq[1] ? 2'b10 : 2'b01;
      mode = $urandom_range(0, 5);
      mode = (mode > 2) ? 0 : mode;
      ew = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4;
      gen_txn(rq, rb(), mode, $urandom_range(0, 15), ew, a, d, rr() & ~g);
    end
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      HReady = sched[i].hready; M_HResp = sched[i].hresp; irq = sched[i].irq;
      DmacReq = sched[i].req; C_config = sched[i].cfg;
      #1;
      checks++;
      if (obs !== sched[i].e) begin
        failures++;
        $display("FAIL random step %0d: got %h expected %h", i, obs, sched[i].e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_bus_err();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
